// File: rtl/tpu_engine_if.sv
// tpu_engine_if: command and result bus of the matrix-multiply engine.
//   Command side : cmd_valid/cmd_ready handshake carrying cmd_op, cmd_row,
//                  cmd_col and cmd_data (operand element loads and RUN).
//   Result side  : out_valid/out_ready stream of out_data tagged with
//                  out_row/out_col, plus out_last on the final element.
//   Status       : busy (computing or draining) and the sticky overflow flag.
// master = command issuer / result consumer, slave = engine.
interface tpu_engine_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
);
  localparam int L = $clog2(N);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [L-1:0]          cmd_row;
  logic [L-1:0]          cmd_col;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [L-1:0]          out_row;
  logic [L-1:0]          out_col;
  logic                  out_last;
  logic                  overflow;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, out_ready,
    input  cmd_ready, busy, out_valid, out_data, out_row, out_col, out_last, overflow
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, out_ready,
    output cmd_ready, busy, out_valid, out_data, out_row, out_col, out_last, overflow
  );
endinterface

// File: rtl/tpu_engine.sv
// tpu_engine: N x N matrix-multiply engine computing C = A x B.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears operands, accumulators,
//           overflow and returns to IDLE
//   bus   : tpu_engine_if slave port
//           - commands (IDLE only): NOP, LOAD_A, LOAD_B, RUN
//           - results streamed row-major over out_valid/out_ready
//           - busy during COMPUTE/DRAIN, sticky per-run overflow
// A RUN clears the accumulators, spends N cycles accumulating one k-slice per
// cycle across the whole N x N MAC grid, then drains the N*N results.
module tpu_engine #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input logic        clk,
  input logic        rst_n,
  tpu_engine_if.slave bus
);
  localparam int L = $clog2(N);

  localparam logic [1:0] OP_LOAD_A = 2'd1;
  localparam logic [1:0] OP_LOAD_B = 2'd2;
  localparam logic [1:0] OP_RUN    = 2'd3;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    (SIGNED != 0) ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    (SIGNED != 0) ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_mem    [N][N];
  logic [DATA_WIDTH-1:0] b_mem    [N][N];
  logic [ACC_WIDTH-1:0]  acc      [N][N];
  logic [ACC_WIDTH-1:0]  acc_next [N][N];
  logic [N*N-1:0]        cell_ovf;
  logic [L-1:0]          k;
  logic [2*L-1:0]        out_idx;
  logic                  overflow_q;

  // MAC grid: operands are sign/zero-extended to 2*DATA_WIDTH so the low
  // half of the product is exact in either mode; the sum is formed one bit
  // wider than the accumulator to detect range exit.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [2*DATA_WIDTH-1:0] a_ext;
      logic [2*DATA_WIDTH-1:0] b_ext;
      logic [2*DATA_WIDTH-1:0] prod;
      logic [ACC_WIDTH:0]      sum;
      logic                    ovf;

      assign a_ext = {{DATA_WIDTH{(SIGNED != 0) && a_mem[gi][k][DATA_WIDTH-1]}}, a_mem[gi][k]};
      assign b_ext = {{DATA_WIDTH{(SIGNED != 0) && b_mem[k][gj][DATA_WIDTH-1]}}, b_mem[k][gj]};
      assign prod  = a_ext * b_ext;
      assign sum   = {{(ACC_WIDTH+1-2*DATA_WIDTH){(SIGNED != 0) && prod[2*DATA_WIDTH-1]}}, prod}
                   + {(SIGNED != 0) && acc[gi][gj][ACC_WIDTH-1], acc[gi][gj]};
      assign ovf   = (SIGNED != 0) ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];

      // Unsigned sums can only leave the range upward, so ACC_MAX applies.
      assign acc_next[gi][gj] = (ovf && (SATURATE != 0))
                              ? ((SIGNED != 0) && sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                              : sum[ACC_WIDTH-1:0];
      assign cell_ovf[gi*N+gj] = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      out_idx    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_LOAD_A: a_mem[bus.cmd_row][bus.cmd_col] <= bus.cmd_data;
              OP_LOAD_B: b_mem[bus.cmd_row][bus.cmd_col] <= bus.cmd_data;
              OP_RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                  for (int unsigned j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                  end
                end
                overflow_q <= 1'b0;
                k          <= '0;
                state      <= COMPUTE;
              end
              default: ;
            endcase
          end
        end
        COMPUTE: begin
          for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
              acc[i][j] <= acc_next[i][j];
            end
          end
          overflow_q <= overflow_q | (|cell_ovf);
          k          <= k + 1'b1;
          if (&k) begin
            state   <= DRAIN;
            out_idx <= '0;
          end
        end
        DRAIN: begin
          // N*N is a power of two, so the index wraps back to 0 on the
          // final handshake.
          if (bus.out_ready) begin
            out_idx <= out_idx + 1'b1;
            if (&out_idx) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_row   = out_idx[2*L-1:L];
  assign bus.out_col   = out_idx[L-1:0];
  assign bus.out_data  = acc[out_idx[2*L-1:L]][out_idx[L-1:0]];
  assign bus.out_last  = (state == DRAIN) && (&out_idx);
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_tpu_engine.sv
// tb_tpu_engine: directed bench for tpu_engine. Three engines (signed wrap,
// signed saturate, unsigned wrap) share identical command/ready stimulus and
// run in lockstep; each test checks the instance(s) its arithmetic targets.
module tb_tpu_engine;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [1:0]    cmd_row;
  logic [1:0]    cmd_col;
  logic [DW-1:0] cmd_data;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  int lat;

  logic [AW-1:0] res_w [16];
  logic [AW-1:0] res_s [16];
  logic [AW-1:0] res_u [16];
  logic          ovf_w, ovf_s, ovf_u;

  always #5 clk = ~clk;

  tpu_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) if_wrap ();
  tpu_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) if_sat ();
  tpu_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) if_uns ();

  assign if_wrap.cmd_valid = cmd_valid;
  assign if_wrap.cmd_op    = cmd_op;
  assign if_wrap.cmd_row   = cmd_row;
  assign if_wrap.cmd_col   = cmd_col;
  assign if_wrap.cmd_data  = cmd_data;
  assign if_wrap.out_ready = out_ready;
  assign if_sat.cmd_valid  = cmd_valid;
  assign if_sat.cmd_op     = cmd_op;
  assign if_sat.cmd_row    = cmd_row;
  assign if_sat.cmd_col    = cmd_col;
  assign if_sat.cmd_data   = cmd_data;
  assign if_sat.out_ready  = out_ready;
  assign if_uns.cmd_valid  = cmd_valid;
  assign if_uns.cmd_op     = cmd_op;
  assign if_uns.cmd_row    = cmd_row;
  assign if_uns.cmd_col    = cmd_col;
  assign if_uns.cmd_data   = cmd_data;
  assign if_uns.out_ready  = out_ready;

  tpu_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1), .SATURATE(0))
    dut_wrap (.clk(clk), .rst_n(rst_n), .bus(if_wrap.slave));
  tpu_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1), .SATURATE(1))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat.slave));
  tpu_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(0), .SATURATE(0))
    dut_uns (.clk(clk), .rst_n(rst_n), .bus(if_uns.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int r, input int c, input logic [DW-1:0] d);
    checks++;
    if (if_wrap.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%b expected 1", if_wrap.cmd_ready);
    end
    cmd_op    = op;
    cmd_row   = 2'(r);
    cmd_col   = 2'(c);
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  // kind 0: A = identity, B[i][j] = 4i+j; 1: all 127; 2: A=-128, B=127; 3: all 255
  task automatic load_mats(input int kind);
    logic [DW-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (kind)
          0: begin a = (i == j) ? 8'd1 : 8'd0; b = 8'(4*i + j); end
          1: begin a = 8'd127; b = 8'd127; end
          2: begin a = 8'h80;  b = 8'd127; end
          default: begin a = 8'hFF; b = 8'hFF; end
        endcase
        issue(2'd1, i, j, a);
        issue(2'd2, i, j, b);
      end
    end
  endtask

  task automatic run_collect(input bit stall, input bit drain_cmd);
    logic [AW-1:0] hold_d;
    logic [1:0]    hold_r, hold_c, exp_r, exp_c;
    bit            stalled;
    int            idx, cyc;
    issue(2'd3, 0, 0, 8'd0);
    checks++;
    if (if_wrap.busy !== 1'b1 || if_wrap.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_start: busy=%b cmd_ready=%b expected busy=1 cmd_ready=0",
               if_wrap.busy, if_wrap.cmd_ready);
    end
    if (drain_cmd) begin
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_row = 2'd0; cmd_col = 2'd0; cmd_data = 8'h55;
    end
    lat = 1;
    while (!if_wrap.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      stalled = 1'b0;
      if (drain_cmd) begin
        checks++;
        if (if_wrap.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL drain_cmd_ready: cmd_ready=%b expected 0", if_wrap.cmd_ready);
        end
      end
      if (if_wrap.out_valid) begin
        exp_r = 2'(idx / 4);
        exp_c = 2'(idx % 4);
        checks++;
        if (if_wrap.out_row !== exp_r || if_wrap.out_col !== exp_c ||
            if_wrap.out_last !== (idx == 15)) begin
          errors++;
          $display("FAIL out_order: row=%0d col=%0d last=%b expected row=%0d col=%0d last=%b",
                   if_wrap.out_row, if_wrap.out_col, if_wrap.out_last, exp_r, exp_c, idx == 15);
        end
        if (out_ready) begin
          res_w[idx] = if_wrap.out_data;
          res_s[idx] = if_sat.out_data;
          res_u[idx] = if_uns.out_data;
          idx++;
          if (idx == 16) cmd_valid = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = if_wrap.out_data;
          hold_r  = if_wrap.out_row;
          hold_c  = if_wrap.out_col;
        end
      end
      tick();
      cyc++;
      if (stalled) begin
        checks++;
        if (if_wrap.out_valid !== 1'b1 || if_wrap.out_data !== hold_d ||
            if_wrap.out_row !== hold_r || if_wrap.out_col !== hold_c) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%0d row=%0d col=%0d expected valid=1 data=%0d row=%0d col=%0d",
                   if_wrap.out_valid, if_wrap.out_data, if_wrap.out_row, if_wrap.out_col,
                   hold_d, hold_r, hold_c);
        end
      end
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (idx != 16) begin
      errors++;
      $display("FAIL drain_timeout: received %0d results expected 16", idx);
    end
    checks++;
    if (if_wrap.out_valid !== 1'b0 || if_wrap.busy !== 1'b0 ||
        if_wrap.cmd_ready !== 1'b1 || if_wrap.out_last !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: valid=%b busy=%b ready=%b last=%b expected 0 0 1 0",
               if_wrap.out_valid, if_wrap.busy, if_wrap.cmd_ready, if_wrap.out_last);
    end
    ovf_w = if_wrap.overflow;
    ovf_s = if_sat.overflow;
    ovf_u = if_uns.overflow;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 2'd0; cmd_col = 2'd0; cmd_data = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (if_wrap.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", if_wrap.cmd_ready); end
    checks++;
    if (if_wrap.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if_wrap.busy); end
    checks++;
    if (if_wrap.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if_wrap.out_valid); end
    checks++;
    if (if_wrap.out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", if_wrap.out_data); end
    checks++;
    if (if_wrap.out_row !== 2'd0 || if_wrap.out_col !== 2'd0) begin
      errors++; $display("FAIL reset_out_idx: got row=%0d col=%0d expected 0 0", if_wrap.out_row, if_wrap.out_col);
    end
    checks++;
    if (if_wrap.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", if_wrap.out_last); end
    checks++;
    if (if_wrap.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", if_wrap.overflow); end
  endtask

  task automatic test_identity();
    load_mats(0);
    run_collect(1'b0, 1'b0);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL identity_latency: got %0d cycles expected 5", lat); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_w[i] !== 16'(i)) begin errors++; $display("FAIL identity_data[%0d]: got %0d expected %0d", i, res_w[i], i); end
    end
    checks++;
    if (ovf_w !== 1'b0) begin errors++; $display("FAIL identity_overflow: got %b expected 0", ovf_w); end
  endtask

  task automatic test_backpressure();
    run_collect(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_w[i] !== 16'(i)) begin errors++; $display("FAIL backpressure_data[%0d]: got %0d expected %0d", i, res_w[i], i); end
    end
  endtask

  task automatic test_signed_overflow();
    load_mats(1);
    run_collect(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_w[i] !== 16'hFC04) begin errors++; $display("FAIL wrap_pos_data[%0d]: got %h expected fc04", i, res_w[i]); end
      checks++;
      if (res_s[i] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_data[%0d]: got %h expected 7fff", i, res_s[i]); end
    end
    checks++;
    if (ovf_w !== 1'b1 || ovf_s !== 1'b1) begin
      errors++; $display("FAIL pos_overflow: wrap=%b sat=%b expected 1 1", ovf_w, ovf_s);
    end
  endtask

  task automatic test_signed_saturate_low();
    load_mats(2);
    run_collect(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_s[i] !== 16'h8000) begin errors++; $display("FAIL sat_neg_data[%0d]: got %h expected 8000", i, res_s[i]); end
    end
    checks++;
    if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_neg_overflow: got %b expected 1", ovf_s); end
  endtask

  task automatic test_unsigned_wrap();
    load_mats(3);
    run_collect(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_u[i] !== 16'd63492) begin errors++; $display("FAIL uns_wrap_data[%0d]: got %0d expected 63492", i, res_u[i]); end
    end
    checks++;
    if (ovf_u !== 1'b1) begin errors++; $display("FAIL uns_overflow: got %b expected 1", ovf_u); end
  endtask

  task automatic test_drain_cmd();
    load_mats(0);
    run_collect(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_w[i] !== 16'(i)) begin errors++; $display("FAIL drain_cmd_data[%0d]: got %0d expected %0d", i, res_w[i], i); end
    end
    run_collect(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_w[i] !== 16'(i)) begin errors++; $display("FAIL rerun_data[%0d]: got %0d expected %0d", i, res_w[i], i); end
    end
  endtask

  task automatic test_reset_mid_compute();
    load_mats(1);
    issue(2'd3, 0, 0, 8'd0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_wrap.cmd_ready !== 1'b1 || if_wrap.busy !== 1'b0 || if_wrap.out_valid !== 1'b0 ||
        if_wrap.out_last !== 1'b0 || if_wrap.overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: ready=%b busy=%b valid=%b last=%b ovf=%b expected 1 0 0 0 0",
               if_wrap.cmd_ready, if_wrap.busy, if_wrap.out_valid, if_wrap.out_last, if_wrap.overflow);
    end
    checks++;
    if (if_wrap.out_data !== 16'd0 || if_wrap.out_row !== 2'd0 || if_wrap.out_col !== 2'd0) begin
      errors++;
      $display("FAIL midreset_data: data=%0d row=%0d col=%0d expected 0 0 0",
               if_wrap.out_data, if_wrap.out_row, if_wrap.out_col);
    end
    #3;
    rst_n = 1'b1;
    tick();
    run_collect(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (res_w[i] !== 16'd0 || res_s[i] !== 16'd0 || res_u[i] !== 16'd0) begin
        errors++;
        $display("FAIL postreset_data[%0d]: got %0d %0d %0d expected 0", i, res_w[i], res_s[i], res_u[i]);
      end
    end
    checks++;
    if (ovf_w !== 1'b0 || ovf_s !== 1'b0 || ovf_u !== 1'b0) begin
      errors++; $display("FAIL postreset_overflow: got %b %b %b expected 0", ovf_w, ovf_s, ovf_u);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_backpressure();
    test_signed_overflow();
    test_signed_saturate_low();
    test_unsigned_wrap();
    test_drain_cmd();
    test_reset_mid_compute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tpu_engine.md
# tpu_engine

Parametrised matrix-multiply engine that computes C = A × B for N×N operand matrices. It holds both operand matrices in internal register files, runs an N-cycle multiply-accumulate sequence over an N×N MAC grid, and streams the N² results out through a valid/ready port. It is the next-generation compute core of the Mini TPU and adds a command handshake, output backpressure, signed/unsigned arithmetic, selectable saturation and an overflow flag.

## Interface
- N, 4: matrix dimension; legal values 2, 4, 8. Let L = log2(N).
- DATA_WIDTH, 8: width of operand elements.
- ACC_WIDTH, 16: width of accumulators and results; must be ≥ 2*DATA_WIDTH.
- SIGNED, 1: 1 = two's-complement operands and results; 0 = unsigned.
- SATURATE, 0: 1 = accumulators clamp at range limits; 0 = accumulators wrap modulo 2^ACC_WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  engine accepts a command; high only in IDLE.
- cmd_op  input  2  0 = NOP, 1 = LOAD_A, 2 = LOAD_B, 3 = RUN.
- cmd_row  input  L  element row for LOAD_A/LOAD_B.
- cmd_col  input  L  element column for LOAD_A/LOAD_B.
- cmd_data  input  DATA_WIDTH  element value for LOAD_A/LOAD_B.
- busy  output  1  high in COMPUTE and DRAIN.
- out_valid  output  1  out_data, out_row, out_col and out_last are valid.
- out_ready  input  1  consumer accepts the presented result.
- out_data  output  ACC_WIDTH  result element C[out_row][out_col].
- out_row, out_col  output  L each  index of the presented element.
- out_last  output  1  high with the final element, C[N-1][N-1].
- overflow  output  1  sticky per-run flag: at least one accumulate step left the ACC_WIDTH range.

## Operation
- A command is accepted on any cycle where cmd_valid and cmd_ready are both high.
- States and transitions:
  - IDLE: LOAD_A and LOAD_B write cmd_data to the addressed element. NOP has no effect. RUN clears all accumulators and overflow, sets k = 0 and moves to COMPUTE.
  - COMPUTE: each cycle, every cell does acc[i][j] += A[i][k] * B[k][j], then k increments. After the k = N-1 cycle, the state moves to DRAIN.
  - DRAIN: results are presented in row-major order, starting at index 0. The index advances on each out_valid && out_ready. After the handshake on index N²-1, the state returns to IDLE.
- Arithmetic:
  - Each product is exact at 2*DATA_WIDTH bits, signed or unsigned per SIGNED, and is extended to ACC_WIDTH+1 bits before the add.
  - If the sum falls outside the ACC_WIDTH range, overflow is set. With SATURATE=1 the accumulator clamps to max/min; otherwise it keeps the low ACC_WIDTH bits.
  - A saturated accumulator continues to accumulate from the clamped value.
- Operand register files are retained across runs. Only reset clears them, to 0.
- cmd_valid outside IDLE is ignored because cmd_ready is low. The command is not queued.
- Reset asserted in any state: the engine returns to IDLE immediately, and operands, accumulators and overflow are cleared.

## Timing
- Reset values: cmd_ready=1, busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, overflow=0.
- A LOAD accepted at edge T is visible to a RUN accepted at edge T+1. Back-to-back loads run at one per cycle.
- For a RUN accepted at edge T:
  - cmd_ready goes low and busy goes high after edge T.
  - The COMPUTE edges are T+1 through T+N.
  - out_valid rises after edge T+N, presenting C[0][0]. Latency from RUN acceptance to the first result is N+1 cycles.
- With out_ready held high, one result transfers per cycle, so DRAIN lasts N² cycles.
- While out_valid && !out_ready, all out_* signals hold stable. out_valid never drops without a handshake.
- After the final handshake at edge E:
  - out_valid, out_last and busy are 0 and cmd_ready is 1 after edge E.
  - The next RUN can be accepted at edge E+1.
- overflow is final once COMPUTE ends. It stays stable throughout DRAIN and IDLE until the next RUN is accepted.

## Test plan
- N=4, SIGNED=1, SATURATE=0. Load A = identity and B[i][j] = 4i+j, then RUN with out_ready=1. Required: out_valid rises 5 cycles after RUN acceptance, outputs are 0..15 in order, out_last is set on value 15, overflow=0.
- Same data with out_ready toggling in the pattern 1,0,0,1. Required: outputs are held while stalled, with no loss or duplication, and the sequence is still 0..15.
- SIGNED=1, ACC_WIDTH=16, all A=127, all B=127 (each sum is 4·16129 = 64516). Required: with SATURATE=1 every out_data = 32767 and overflow=1; with SATURATE=0 every out_data = -1020 and overflow=1.
- SIGNED=1, SATURATE=1, all A=-128, all B=127 (each sum is -65024). Required: every out_data = -32768 (0x8000). SIGNED=0 with all A=B=255 (sum 260100): wrap mode gives 63492.
- During DRAIN, drive cmd_valid=1 with LOAD_A. Required: cmd_ready=0 and A is unchanged; a second RUN reproduces identical results.
- Assert rst_n low mid-COMPUTE (k=2). Required: all outputs take their reset values at once; after release, a RUN with no loads returns 16 zeros and overflow=0.
